sparse_shift_add_multiplier: RTL



---
 rtl/mult_pkg.sv | 26 ++
 rtl/lsb_set_bit_extract.sv | 32 +++
 rtl/sparse_shift_add_multiplier.sv | 117 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sparse shift-add multiplier.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   prod_width : full-precision product width for given operand widths
//   popcount   : number of set bits in a vector (up to 64 bits)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lsb_set_bit_extract.sv
// Picks the lowest K set bits of a mask.
//   mask      : in  W  candidate bits
//   onehot    : out K x W, slot k holds the k-th lowest set bit (one-hot) or 0
//   slot_vld  : out K, slot k found a set bit
//   mask_next : out W, mask with the selected bits cleared
module lsb_set_bit_extract #(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic [W-1:0]        mask,
  output logic [K-1:0][W-1:0] onehot,
  output logic [K-1:0]        slot_vld,
  output logic [W-1:0]        mask_next
);

  logic [W-1:0] m;

  // Each slot isolates the lowest remaining set bit (m & -m) and then
  // removes it so the next slot sees the following one.
  always_comb begin
    m         = mask;
    onehot    = '0;
    slot_vld  = '0;
    for (int k = 0; k < K; k++) begin
      onehot[k]   = m & (~m + W'(1));
      slot_vld[k] = |m;
      m           = m & ~onehot[k];
    end
    mask_next = m;
  end

endmodule

// File: rtl/sparse_shift_add_multiplier.sv
// Sequential unsigned multiplier c = a * b built from shifted copies of a,
// one per set bit of b, retiring up to ONES_PER_CYCLE set bits per clock.
//   clk, rst_n       : clock, synchronous active-low reset
//   in_vld / in_rdy  : operand handshake (a, b sampled on accept)
//   out_vld / out_rdy: product handshake (c, ones held while stalled)
//   c                : full-precision product, A_W+B_W bits
//   ones             : popcount(b) of the current result
module sparse_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter  int A_W            = 16,
  parameter  int B_W            = 8,
  parameter  int ONES_PER_CYCLE = 2,
  localparam int C_W            = prod_width(A_W, B_W),
  localparam int ONES_W         = $clog2(B_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [A_W-1:0]    a,
  input  logic [B_W-1:0]    b,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [C_W-1:0]    c,
  output logic [ONES_W-1:0] ones
);

  state_t state, state_nxt;

  logic [C_W-1:0]    a_q;
  logic [C_W-1:0]    acc;
  logic [C_W-1:0]    c_q;
  logic [B_W-1:0]    rem;
  logic [ONES_W-1:0] ones_q;

  logic [ONES_PER_CYCLE-1:0][B_W-1:0] onehot;
  logic [ONES_PER_CYCLE-1:0]          slot_vld;
  logic [B_W-1:0]                     rem_nxt;
  logic [C_W-1:0]                     part [ONES_PER_CYCLE];
  logic [C_W-1:0]                     add_sum;
  logic [C_W-1:0]                     acc_nxt;

  lsb_set_bit_extract #(
    .W (B_W),
    .K (ONES_PER_CYCLE)
  ) u_extract (
    .mask      (rem),
    .onehot    (onehot),
    .slot_vld  (slot_vld),
    .mask_next (rem_nxt)
  );

  // Each slot is one-hot, so its shifted copy of a is a plain OR-mux;
  // only the K slot results need real adders.
  always_comb begin
    add_sum = '0;
    for (int k = 0; k < ONES_PER_CYCLE; k++) begin
      part[k] = '0;
      for (int j = 0; j < B_W; j++) begin
        if (onehot[k][j]) part[k] = part[k] | (a_q << j);
      end
      if (slot_vld[k]) add_sum = add_sum + part[k];
    end
    acc_nxt = acc + add_sum;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = BUSY;
      end
      BUSY: begin
        // b == 0 also lands here: rem_nxt is already zero after one cycle.
        if (rem_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: controller state plus operand/accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      acc    <= '0;
      c_q    <= '0;
      rem    <= '0;
      ones_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_vld) begin
        a_q    <= C_W'(a);
        rem    <= b;
        acc    <= '0;
        ones_q <= ONES_W'(popcount(64'(b)));
      end
      if (state == BUSY) begin
        acc <= acc_nxt;
        rem <= rem_nxt;
        if (rem_nxt == '0) c_q <= acc_nxt;
      end
    end
  end

  assign c    = c_q;
  assign ones = ones_q;

endmodule
